// File: rtl/product_accumulator.sv
// ---------------------------------------------------------------------------
// product_accumulator
//
// Sums a sequence of signed products from an upstream multiplier into a wide
// accumulator, then rounds (half up) and right-shifts by FRAC_BITS to form a
// signed OUT_WIDTH result. Each accumulation is terminated by in_last or by
// reaching MAX_TERMS terms; the latter also sets the sticky err_overrun flag.
//
// Build option:
//   ACC_SATURATE_EN  defined   -> out-of-range results clamp, out_sat = 1
//                    undefined -> result wraps to OUT_WIDTH bits, out_sat = 0
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds its payload until that edge; the block
// holds out_data/out_sat/out_valid stable until out_valid && out_ready.
//
// Parameters:
//   P_WIDTH    signed product width
//   ACC_WIDTH  signed accumulator width (>= P_WIDTH + 4)
//   OUT_WIDTH  signed result width (< ACC_WIDTH + 1)
//   FRAC_BITS  output right shift (>= 1)
//   MAX_TERMS  maximum products per accumulation
//
// Ports:
//   clk, rst_n       clock, asynchronous active-low reset
//   in_valid         in_product/in_last valid
//   in_ready         term accepted this cycle (1 in IDLE/ACCUM, 0 in HOLD)
//   in_product       signed product
//   in_last          final term of the accumulation
//   out_valid        out_data holds a result
//   out_ready        consumer accepts the result
//   out_data         signed rounded result
//   out_sat          result was clipped (qualified by out_valid)
//   err_overrun      sticky: MAX_TERMS reached without in_last
// ---------------------------------------------------------------------------
module product_accumulator #(
    parameter int P_WIDTH   = 64,
    parameter int ACC_WIDTH = 72,
    parameter int OUT_WIDTH = 32,
    parameter int FRAC_BITS = 30,
    parameter int MAX_TERMS = 5
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [P_WIDTH-1:0]   in_product,
    input  logic                 in_last,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [OUT_WIDTH-1:0] out_data,
    output logic                 out_sat,
    output logic                 err_overrun
);

    localparam int CNT_W = $clog2(MAX_TERMS + 1);
    // Rounding is done one bit wider than the accumulator so it cannot wrap.
    localparam int RW    = ACC_WIDTH + 1;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_TERMS);
    localparam logic [CNT_W-1:0] ONE_CNT = CNT_W'(1);
    localparam logic [RW-1:0]    RND_C   = RW'(1) << (FRAC_BITS - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [ACC_WIDTH-1:0]   acc_q, acc_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   out_valid_q, out_valid_d;
    logic [OUT_WIDTH-1:0]   out_data_q, out_data_d;
    logic                   out_sat_q, out_sat_d;
    logic                   err_q, err_d;

    logic                   accept;
    logic [ACC_WIDTH-1:0]   term_ext;
    logic [ACC_WIDTH-1:0]   acc_sum;
    logic [CNT_W-1:0]       cnt_inc;
    logic                   hit_max;
    logic                   is_last;
    logic [RW-1:0]          rnd_sum;
    logic signed [RW-1:0]   shifted;
    logic [OUT_WIDTH-1:0]   res_data;
    logic                   res_sat;

    assign in_ready    = (state_q != ST_HOLD);
    assign accept      = in_valid && in_ready;
    assign out_valid   = out_valid_q;
    assign out_data    = out_data_q;
    assign out_sat     = out_sat_q;
    assign err_overrun = err_q;

    // Datapath for the term arriving this cycle: the first term of an
    // accumulation replaces the accumulator, later ones add to it.
    always_comb begin
        term_ext = {{(ACC_WIDTH-P_WIDTH){in_product[P_WIDTH-1]}}, in_product};
        if (state_q == ST_IDLE) begin
            acc_sum = term_ext;
            cnt_inc = ONE_CNT;
        end else begin
            acc_sum = acc_q + term_ext;
            cnt_inc = cnt_q + ONE_CNT;
        end
        hit_max = (cnt_inc == MAX_CNT);
        is_last = in_last || hit_max;
        rnd_sum = {acc_sum[ACC_WIDTH-1], acc_sum} + RND_C;
        shifted = $signed(rnd_sum) >>> FRAC_BITS;
    end

`ifdef ACC_SATURATE_EN
    logic [RW-OUT_WIDTH:0] upper;
    logic                  fits;

    // The shifted value fits OUT_WIDTH when every bit from the result sign
    // position upward agrees.
    always_comb begin
        upper = shifted[RW-1:OUT_WIDTH-1];
        fits  = (&upper) || !(|upper);
        if (fits) begin
            res_data = shifted[OUT_WIDTH-1:0];
        end else if (shifted[RW-1]) begin
            res_data = {1'b1, {(OUT_WIDTH-1){1'b0}}};
        end else begin
            res_data = {1'b0, {(OUT_WIDTH-1){1'b1}}};
        end
        res_sat = !fits;
    end
`else
    logic unused_hi;

    // Wrapping keeps only the low OUT_WIDTH bits of the shifted value.
    assign unused_hi = ^shifted[RW-1:OUT_WIDTH];

    always_comb begin
        res_data = shifted[OUT_WIDTH-1:0];
        res_sat  = 1'b0;
    end
`endif

    // Next-state logic for the control FSM and all registered outputs.
    always_comb begin
        state_d     = state_q;
        acc_d       = acc_q;
        cnt_d       = cnt_q;
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        err_d       = err_q;

        case (state_q)
            ST_IDLE, ST_ACCUM: begin
                // in_valid low leaves acc/count untouched (bubble).
                if (accept) begin
                    acc_d = acc_sum;
                    cnt_d = cnt_inc;
                    if (is_last) begin
                        state_d     = ST_HOLD;
                        out_valid_d = 1'b1;
                        out_data_d  = res_data;
                        out_sat_d   = res_sat;
                        // Hitting the term limit without in_last is an overrun.
                        if (!in_last) begin
                            err_d = 1'b1;
                        end
                    end else begin
                        state_d = ST_ACCUM;
                    end
                end
            end
            ST_HOLD: begin
                // No term is taken on the handoff cycle; IDLE accepts next.
                if (out_ready) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b0;
                    cnt_d       = '0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            acc_q       <= '0;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            err_q       <= err_d;
        end
    end

endmodule

// File: tb/tb_product_accumulator.sv
// ---------------------------------------------------------------------------
// tb_product_accumulator
//
// Testbench for product_accumulator with default parameters. A reference
// model computes each expected result on term acceptance and pushes it to a
// queue; a negedge monitor pops and compares on every output handoff.
// Directed sequences also check result values, latency and holding directly.
// Honours ACC_SATURATE_EN in the same way as the design.
// ---------------------------------------------------------------------------
module tb_product_accumulator;

    localparam int P_WIDTH   = 64;
    localparam int ACC_WIDTH = 72;
    localparam int OUT_WIDTH = 32;
    localparam int FRAC_BITS = 30;
    localparam int MAX_TERMS = 5;

    localparam logic signed [127:0] OUT_MAXV = 128'sd2147483647;
    localparam logic signed [127:0] OUT_MINV = -128'sd2147483648;

    // ---------------- clock / reset ----------------
    logic                 clk;
    logic                 rst_n;
    logic                 in_valid;
    logic                 in_ready;
    logic [P_WIDTH-1:0]   in_product;
    logic                 in_last;
    logic                 out_valid;
    logic                 out_ready;
    logic [OUT_WIDTH-1:0] out_data;
    logic                 out_sat;
    logic                 err_overrun;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    product_accumulator #(
        .P_WIDTH  (P_WIDTH),
        .ACC_WIDTH(ACC_WIDTH),
        .OUT_WIDTH(OUT_WIDTH),
        .FRAC_BITS(FRAC_BITS),
        .MAX_TERMS(MAX_TERMS)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_product (in_product),
        .in_last    (in_last),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sat    (out_sat),
        .err_overrun(err_overrun)
    );

    // ---------------- scoreboard state ----------------
    logic [OUT_WIDTH:0]   exp_q[$];   // {sat, data}
    int                   n_vec;
    int                   n_err;
    logic signed [127:0]  m_acc;
    int                   m_cnt;
    logic                 m_err;
    logic                 rand_or;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: floor((acc + 2^(F-1)) / 2^F) then clamp or wrap.
    task automatic model_accept(input logic [P_WIDTH-1:0] p, input logic last);
        logic signed [127:0] t;
        logic signed [127:0] r;
        logic [OUT_WIDTH-1:0] d;
        logic s;
        t = {{(128-P_WIDTH){p[P_WIDTH-1]}}, p};
        if (m_cnt == 0) m_acc = t;
        else m_acc = m_acc + t;
        m_cnt++;
        if (last || m_cnt == MAX_TERMS) begin
            r = (m_acc + (128'sd1 <<< (FRAC_BITS - 1))) >>> FRAC_BITS;
`ifdef ACC_SATURATE_EN
            if (r > OUT_MAXV) begin
                d = 32'h7FFF_FFFF;
                s = 1'b1;
            end else if (r < OUT_MINV) begin
                d = 32'h8000_0000;
                s = 1'b1;
            end else begin
                d = r[OUT_WIDTH-1:0];
                s = 1'b0;
            end
`else
            d = r[OUT_WIDTH-1:0];
            s = 1'b0;
`endif
            exp_q.push_back({s, d});
            if (!last) m_err = 1'b1;
            m_cnt = 0;
        end
    endtask

    task automatic model_reset();
        m_acc = '0;
        m_cnt = 0;
        m_err = 1'b0;
        exp_q.delete();
    endtask

    // ---------------- monitor ----------------
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_result", 1, 0);
            end else begin
                check("result", {out_sat, out_data}, exp_q.pop_front());
            end
        end
    end

    // Random backpressure, active only during the random phase.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (rand_or) out_ready = 1'($urandom_range(0, 1));
        end
    end

    // ---------------- driver tasks ----------------
    // Entered and left at posedge+1.
    task automatic send_term(input logic [P_WIDTH-1:0] p, input logic last, input int bubbles);
        logic took;
        took = 1'b0;
        in_valid = 1'b0;
        repeat (bubbles) begin
            @(posedge clk);
            #1;
        end
        in_valid   = 1'b1;
        in_product = p;
        in_last    = last;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            took = in_ready;
            @(posedge clk);
            #1;
            if (took) break;
        end
        in_valid = 1'b0;
        in_last  = 1'b0;
        if (took) model_accept(p, last);
        else check("accept_timeout", 0, 1);
    endtask

    // Checks the result in the cycle after the last accept, then realigns.
    task automatic wait_result(input string tag, input logic [OUT_WIDTH-1:0] d, input logic s);
        @(negedge clk);
        check({tag, "_valid"}, out_valid, 1);
        check({tag, "_data"}, out_data, d);
        check({tag, "_sat"}, out_sat, s);
        @(posedge clk);
        #1;
    endtask

    localparam logic [P_WIDTH-1:0] T30 = 64'h0000_0000_4000_0000;
    localparam logic [P_WIDTH-1:0] T29 = 64'h0000_0000_2000_0000;
    localparam logic [P_WIDTH-1:0] N29 = 64'hFFFF_FFFF_E000_0000;
    localparam logic [P_WIDTH-1:0] T62 = 64'h4000_0000_0000_0000;

    // ---------------- main sequence ----------------
    initial begin
        logic [P_WIDTH-1:0] p;
        logic [31:0]        r32;
        int                 len;
        n_vec      = 0;
        n_err      = 0;
        rand_or    = 1'b0;
        rst_n      = 1'b0;
        in_valid   = 1'b0;
        in_product = '0;
        in_last    = 1'b0;
        out_ready  = 1'b1;
        model_reset();

        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_out_sat", out_sat, 0);
        check("rst_err", err_overrun, 0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_in_ready", in_ready, 1);
        @(posedge clk);
        #1;

        // Three terms of 2^30 -> 3, result one cycle after the last accept.
        send_term(T30, 1'b0, 0);
        send_term(T30, 1'b0, 1);
        send_term(T30, 1'b1, 0);
        wait_result("sum3", 32'd3, 1'b0);

        // Half rounds up; negative half rounds toward +inf to 0.
        send_term(T29, 1'b1, 0);
        wait_result("half_pos", 32'd1, 1'b0);
        send_term(N29, 1'b1, 0);
        wait_result("half_neg", 32'd0, 1'b0);

        // Large sum: clamps when saturating, wraps to 0 otherwise.
        send_term(T62, 1'b0, 0);
        send_term(T62, 1'b1, 0);
`ifdef ACC_SATURATE_EN
        wait_result("big", 32'h7FFF_FFFF, 1'b1);
`else
        wait_result("big", 32'd0, 1'b0);
`endif

        // Hold with backpressure while the producer keeps offering a term.
        out_ready = 1'b0;
        send_term(64'd7 << 30, 1'b1, 0);
        wait_result("hold0", 32'd7, 1'b0);
        in_valid   = 1'b1;
        in_product = T30;
        in_last    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold_in_ready", in_ready, 0);
            check("hold_valid", out_valid, 1);
            check("hold_data", out_data, 7);
            @(posedge clk);
            #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("handoff_in_ready", in_ready, 0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        @(negedge clk);
        check("post_handoff_in_ready", in_ready, 1);
        check("post_handoff_valid", out_valid, 0);
        @(posedge clk);
        #1;

        // Overrun: fifth term closes the accumulation, sixth starts anew.
        for (int i = 0; i < 4; i++) send_term(T30, 1'b0, 0);
        check("pre_overrun_err", err_overrun, 0);
        send_term(T30, 1'b0, 0);
        @(negedge clk);
        check("overrun_valid", out_valid, 1);
        check("overrun_data", out_data, 5);
        check("overrun_err", err_overrun, 1);
        @(posedge clk);
        #1;
        send_term(T30, 1'b0, 0);
        send_term(T30, 1'b1, 0);
        wait_result("after_overrun", 32'd2, 1'b0);
        check("err_sticky", err_overrun, 1);

        // Reset mid-accumulation discards everything.
        send_term(T30, 1'b0, 0);
        send_term(T30, 1'b0, 0);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("midrst_valid", out_valid, 0);
        check("midrst_data", out_data, 0);
        check("midrst_sat", out_sat, 0);
        check("midrst_err", err_overrun, 0);
        check("midrst_in_ready", in_ready, 1);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("midrst_no_pulse", out_valid, 0);
            @(posedge clk);
            #1;
        end
        send_term(T30, 1'b1, 0);
        wait_result("after_rst", 32'd1, 1'b0);

        // Random accumulations with bubbles and random backpressure.
        rand_or = 1'b1;
        for (int n = 0; n < 40; n++) begin
            len = $urandom_range(1, MAX_TERMS);
            for (int k = 0; k < len; k++) begin
                r32 = $urandom;
                if ($urandom_range(0, 3) == 0) begin
                    p = {$urandom, r32};
                end else begin
                    p = {{32{r32[31]}}, r32};
                    p = p << $urandom_range(0, 8);
                end
                send_term(p, (k == len - 1), $urandom_range(0, 2));
            end
        end
        rand_or = 1'b0;
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        for (int i = 0; i < 100; i++) begin
            if (exp_q.size() == 0) break;
            @(posedge clk);
            #1;
        end
        check("drain_empty", exp_q.size(), 0);
        check("final_err", err_overrun, m_err);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/product_accumulator.md
PRODUCT_ACCUMULATOR -- requirements
Module: product_accumulator

Interface
REQ-001 SHALL have parameter P_WIDTH, default 64, width of the signed product input (A_WIDTH+B_WIDTH of the upstream multiplier).
REQ-002 SHALL have parameter ACC_WIDTH, default 72, signed accumulator width; must be >= P_WIDTH+4.
REQ-003 SHALL have parameter OUT_WIDTH, default 32, signed result width.
REQ-004 SHALL have parameter FRAC_BITS, default 30, right shift applied to the accumulator on output; must be >= 1.
REQ-005 SHALL have parameter MAX_TERMS, default 5, maximum products per accumulation.
REQ-006 SHALL have port clk, input, 1, sole clock; all state on rising edge.
REQ-007 SHALL have port rst_n, input, 1, reset, asynchronous and active-low.
REQ-008 SHALL have port in_valid, input, 1, in_product/in_last valid this cycle.
REQ-009 SHALL have port in_ready, output, 1, block accepts a term this cycle.
REQ-010 SHALL have port in_product, input, P_WIDTH, signed product from multiplier.
REQ-011 SHALL have port in_last, input, 1, marks the final term of an accumulation.
REQ-012 SHALL have port out_valid, output, 1, out_data holds a result.
REQ-013 SHALL have port out_ready, input, 1, consumer accepts result.
REQ-014 SHALL have port out_data, output, OUT_WIDTH, signed rounded result.
REQ-015 SHALL have port out_sat, output, 1, result was clipped; qualified by out_valid.
REQ-016 SHALL have port err_overrun, output, 1, sticky: MAX_TERMS reached without in_last.

Function
REQ-017 SHALL implement states IDLE, ACCUM, HOLD.
REQ-018 Term accepted only when in_valid && in_ready; in_ready = 1 in IDLE and ACCUM, 0 in HOLD.
REQ-019 IDLE: accepted term loads acc = sign-extended in_product, term count = 1; goes to ACCUM, or HOLD if in_last.
REQ-020 ACCUM: accepted term does acc += sign-extended in_product (ACC_WIDTH, two's-complement wrap) and increments count; in_last goes to HOLD.
REQ-021 When the MAX_TERMS-th term is accepted without in_last, it SHALL be treated as last, err_overrun set, and state goes to HOLD.
REQ-022 Entering HOLD: result = (acc_final + 2^(FRAC_BITS-1)) >>> FRAC_BITS (round half up, arithmetic shift); registered to out_data with out_valid = 1 in the cycle after the last term is accepted (latency 1).
REQ-023 HOLD: out_data, out_sat, out_valid SHALL remain stable until out_valid && out_ready; on that cycle state goes to IDLE, out_valid drops next cycle.
REQ-024 No term is accepted in the cycle the result is handed off; next term is accepted earliest one cycle later (IDLE).
REQ-025 in_valid low in ACCUM SHALL hold acc and count unchanged (bubbles allowed).
REQ-026 Rounding addition SHALL be performed at ACC_WIDTH+1 bits so it cannot wrap.

Reset
REQ-027 rst_n low SHALL asynchronously force state IDLE, acc 0, count 0, out_valid 0, out_data 0, out_sat 0, err_overrun 0; in_ready reads 1 after release.
REQ-028 Reset mid-accumulation or in HOLD SHALL discard the partial/held result; no out_valid pulse follows.

Configuration
REQ-029 Macro ACC_SATURATE_EN defined: shifted result outside [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1] clamps to the nearest bound and out_sat = 1.
REQ-030 ACC_SATURATE_EN undefined: out_data = low OUT_WIDTH bits of the shifted result (wrap), out_sat tied 0.

Verification
REQ-031 Terms 2^30, 2^30, 2^30 (last), out_ready=1 -> out_data=3, out_sat=0, out_valid one cycle after third accept.
REQ-032 Single term 2^29 (last) -> out_data=1 (half rounds up); single term -2^29 -> out_data=0.
REQ-033 ACC_SATURATE_EN, terms 2^62, 2^62 (last) -> out_data=32'h7FFFFFFF, out_sat=1; without macro -> out_data=0, out_sat=0.
REQ-034 Result held with out_ready=0 for 5 cycles while in_valid=1 -> in_ready=0, out_data stable, no term absorbed; out_ready=1 -> handoff, in_ready=1 next cycle.
REQ-035 Six terms of 2^30, no in_last, MAX_TERMS=5 -> out_data=5 after fifth, err_overrun=1; sixth term starts a new accumulation.
REQ-036 rst_n pulsed low mid-accumulation after two terms -> all outputs 0 immediately; subsequent single term 2^30 (last) -> out_data=1.
